// File: rtl/store_buffer_if.sv
// -----------------------------------------------------------------------------
// store_buffer_if
// Memory-side bus between store_buffer and data_memory.
//
// Signals
//   mem_addr        byte address presented to data_memory
//   mem_write_data  write data presented to data_memory
//   mem_MemRead     data_memory read enable
//   mem_MemWrite    data_memory write enable
//   mem_read_data   data_memory read data (combinational read)
//
// Modports
//   master  store_buffer side (drives address/data/enables)
//   slave   data_memory side (drives read data)
// -----------------------------------------------------------------------------
interface store_buffer_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_write_data;
  logic          mem_MemRead;
  logic          mem_MemWrite;
  logic [DW-1:0] mem_read_data;

  modport master (
    output mem_addr, mem_write_data, mem_MemRead, mem_MemWrite,
    input  mem_read_data
  );

  modport slave (
    input  mem_addr, mem_write_data, mem_MemRead, mem_MemWrite,
    output mem_read_data
  );
endinterface

// File: rtl/store_buffer.sv
// -----------------------------------------------------------------------------
// store_buffer
// Posted-write FIFO between a single-cycle datapath and data_memory. Stores
// retire into the buffer without using the memory port; buffered stores drain
// into data_memory on any cycle whose load does not need the port. Loads stay
// coherent with pending stores by forwarding or by stalling.
//
// Configuration macro
//   STORE_FWD_EN  defined   : a load hitting a pending store returns the
//                             youngest matching data from the buffer, no stall,
//                             and the head still drains that cycle.
//                 undefined : a load hitting a pending store stalls while the
//                             buffer drains, then reads data_memory.
//
// Parameters
//   DEPTH  number of store entries (power of two, >= 2)
//   AW/DW  address / data width
//
// Ports
//   clk, rst_n      rising-edge clock, asynchronous active-low reset
//   cpu_addr        byte address from the ALU
//   cpu_wdata       store data
//   cpu_MemRead     load request
//   cpu_MemWrite    store request (wins if both requests are raised)
//   cpu_rdata       load data to write-back (0 when no load)
//   stall           hold PC / pipeline registers this cycle
//   mem             store_buffer_if.master to data_memory
//   empty/full      no pending stores / count == DEPTH
//   count           number of valid entries
// -----------------------------------------------------------------------------
module store_buffer #(
  parameter int DEPTH = 4,
  parameter int AW    = 32,
  parameter int DW    = 32
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [AW-1:0]          cpu_addr,
  input  logic [DW-1:0]          cpu_wdata,
  input  logic                   cpu_MemRead,
  input  logic                   cpu_MemWrite,
  output logic [DW-1:0]          cpu_rdata,
  output logic                   stall,
  store_buffer_if.master         mem,
  output logic                   empty,
  output logic                   full,
  output logic [$clog2(DEPTH):0] count
);

  localparam int PW = $clog2(DEPTH);

  logic [AW-1:0]    addr_q [DEPTH];
  logic [DW-1:0]    data_q [DEPTH];
  logic [DEPTH-1:0] valid_q;
  logic [PW-1:0]    rd_ptr;
  logic [PW-1:0]    wr_ptr;
  logic [PW:0]      count_q;

  logic             is_load;
  logic             enq;
  logic             deq;
  logic             match_any;
  logic             load_port;
  logic [PW-1:0]    scan_idx;
`ifdef STORE_FWD_EN
  logic [DW-1:0]    fwd_data;
`endif

  assign empty   = (count_q == '0);
  assign full    = (count_q == (PW+1)'(DEPTH));
  assign count   = count_q;

  // A simultaneous load+store request is treated as a store only.
  assign is_load = cpu_MemRead & ~cpu_MemWrite;
  // Registered full: a same-cycle drain does not make room for this store.
  assign enq     = cpu_MemWrite & ~full;

  // Word-granular match against valid entries. Scanning oldest to youngest
  // lets the last hit overwrite earlier ones, leaving the youngest match.
  // NOTE: every variable written here gets a default first, so no latch is inferred.
  always_comb begin
    match_any = 1'b0;
    scan_idx  = '0;
`ifdef STORE_FWD_EN
    fwd_data  = '0;
`endif
    for (int k = 0; k < DEPTH; k++) begin
      scan_idx = rd_ptr + PW'(k);
      if (valid_q[scan_idx] && (addr_q[scan_idx][AW-1:2] == cpu_addr[AW-1:2])) begin
        match_any = 1'b1;
`ifdef STORE_FWD_EN
        fwd_data  = data_q[scan_idx];
`endif
      end
    end
  end

  // A hitting load never takes the port: it is either forwarded or stalled.
  assign load_port = is_load & ~match_any;
  assign deq       = ~load_port & ~empty;

  always_comb begin
    mem.mem_MemRead    = load_port;
    mem.mem_MemWrite   = deq;
    mem.mem_addr       = cpu_addr;
    mem.mem_write_data = '0;
    if (deq) begin
      mem.mem_addr       = addr_q[rd_ptr];
      mem.mem_write_data = data_q[rd_ptr];
    end
  end

`ifdef STORE_FWD_EN
  always_comb begin
    cpu_rdata = '0;
    if (is_load) cpu_rdata = match_any ? fwd_data : mem.mem_read_data;
  end
  assign stall = cpu_MemWrite & full;
`else
  assign cpu_rdata = load_port ? mem.mem_read_data : '0;
  assign stall     = (cpu_MemWrite & full) | (is_load & match_any);
`endif

  // Control state. Reset discards every pending store, even mid-drain.
  // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      count_q <= '0;
      valid_q <= '0;
    end else begin
      if (enq) begin
        valid_q[wr_ptr] <= 1'b1;
        wr_ptr          <= wr_ptr + 1'b1;
      end
      if (deq) begin
        valid_q[rd_ptr] <= 1'b0;
        rd_ptr          <= rd_ptr + 1'b1;
      end
      case ({enq, deq})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // NOTE: the payload array has no reset; valid_q alone decides whether an entry means anything.
  always_ff @(posedge clk) begin
    if (enq) begin
      addr_q[wr_ptr] <= cpu_addr;
      data_q[wr_ptr] <= cpu_wdata;
    end
  end

endmodule

// File: tb/tb_store_buffer.sv
// -----------------------------------------------------------------------------
// tb_store_buffer
// Scoreboard bench for store_buffer. The stimulus process drives one request
// per cycle and, from a queue-based reference model (pending-store list plus a
// word memory image), pushes the expected per-cycle stall / drain / count, the
// expected load data and the expected memory-write order. A negedge monitor
// pops and compares whenever the DUT shows the matching event.
// Build with +define+STORE_FWD_EN to exercise forwarding.
// -----------------------------------------------------------------------------
module tb_store_buffer;

  localparam int DEPTH = 4;
  localparam int AW    = 32;
  localparam int DW    = 32;
  localparam int NW    = 16;
  localparam int CW    = $clog2(DEPTH) + 1;
`ifdef STORE_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  typedef struct {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } store_t;

  typedef struct {
    logic          stall;
    logic          drain;
    logic [CW-1:0] cnt;
  } cyc_exp_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [AW-1:0] cpu_addr = '0;
  logic [DW-1:0] cpu_wdata = '0;
  logic          cpu_MemRead = 1'b0;
  logic          cpu_MemWrite = 1'b0;
  logic [DW-1:0] cpu_rdata;
  logic          stall;
  logic          empty;
  logic          full;
  logic [CW-1:0] count;

  store_buffer_if #(.AW(AW), .DW(DW)) mem_if ();

  store_buffer #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .cpu_addr     (cpu_addr),
    .cpu_wdata    (cpu_wdata),
    .cpu_MemRead  (cpu_MemRead),
    .cpu_MemWrite (cpu_MemWrite),
    .cpu_rdata    (cpu_rdata),
    .stall        (stall),
    .mem          (mem_if.master),
    .empty        (empty),
    .full         (full),
    .count        (count)
  );

  always #5 clk = ~clk;

  // data_memory stand-in: word i starts at 5 + 15*i, combinational read.
  logic [DW-1:0] dmem [NW] = '{32'd5, 32'd20, 32'd35, 32'd50, 32'd65, 32'd80, 32'd95, 32'd110,
                               32'd125, 32'd140, 32'd155, 32'd170, 32'd185, 32'd200, 32'd215, 32'd230};
  assign mem_if.mem_read_data = dmem[mem_if.mem_addr[5:2]];
  always @(posedge clk) begin
    if (mem_if.mem_MemWrite) dmem[mem_if.mem_addr[5:2]] <= mem_if.mem_write_data;
  end

  // Reference model and scoreboard queues
  store_t        pq [$];
  store_t        wr_q [$];
  logic [DW-1:0] rd_q [$];
  cyc_exp_t      cyc_q [$];
  logic [DW-1:0] ref_mem [NW];

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Youngest pending store to the same word, else the memory image.
  function automatic bit lookup(input logic [AW-1:0] a, output logic [DW-1:0] v);
    bit found = 1'b0;
    v = ref_mem[a[5:2]];
    for (int i = 0; i < pq.size(); i++) begin
      if (pq[i].addr[AW-1:2] == a[AW-1:2]) begin
        found = 1'b1;
        v     = pq[i].data;
      end
    end
    return found;
  endfunction

  // One clock of stimulus; queues expectations, then advances the model.
  task automatic cycle(input bit rd, input bit wr, input logic [AW-1:0] a,
                       input logic [DW-1:0] d, output bit done);
    bit            ld;
    bit            hit;
    bit            exp_stall;
    bit            exp_drain;
    logic [DW-1:0] v;
    store_t        s;
    @(posedge clk);
    #1;
    cpu_MemRead  = rd;
    cpu_MemWrite = wr;
    cpu_addr     = a;
    cpu_wdata    = d;
    ld        = rd && !wr;
    hit       = lookup(a, v);
    exp_stall = (wr && pq.size() == DEPTH) || (!FWD && ld && hit);
    exp_drain = !(ld && !hit) && pq.size() != 0;
    cyc_q.push_back('{stall: exp_stall, drain: exp_drain, cnt: CW'(pq.size())});
    if (rd && !exp_stall) rd_q.push_back(ld ? v : '0);
    if (wr && !exp_stall) wr_q.push_back('{addr: a, data: d});
    if (exp_drain) begin
      s = pq.pop_front();
      ref_mem[s.addr[5:2]] = s.data;
    end
    if (wr && !exp_stall) pq.push_back('{addr: a, data: d});
    done = !exp_stall;
  endtask

  // Present a request until it is accepted, with a bounded cycle budget.
  task automatic do_op(input bit rd, input bit wr, input logic [AW-1:0] a, input logic [DW-1:0] d);
    bit done = 1'b0;
    for (int n = 0; n < 8 && !done; n++) cycle(rd, wr, a, d, done);
    if (!done) check("op_accept_timeout", done, 1);
  endtask

  // Monitor: compares whenever the DUT presents a cycle, a write or a load result.
  always @(negedge clk) begin
    cyc_exp_t e;
    store_t   w;
    if (rst_n && cyc_q.size() > 0) begin
      e = cyc_q.pop_front();
      check("stall", stall, e.stall);
      check("mem_MemWrite", mem_if.mem_MemWrite, e.drain);
      check("count", count, e.cnt);
      if (mem_if.mem_MemWrite) begin
        if (wr_q.size() == 0) check("unexpected_mem_write", mem_if.mem_MemWrite, 0);
        else begin
          w = wr_q.pop_front();
          check("mem_write_addr", mem_if.mem_addr, w.addr);
          check("mem_write_data", mem_if.mem_write_data, w.data);
        end
      end
      if (cpu_MemRead && !stall) begin
        if (rd_q.size() == 0) check("unexpected_load_result", cpu_MemRead, 0);
        else check("cpu_rdata", cpu_rdata, rd_q.pop_front());
      end
    end
  end

  initial begin
    bit done;
    for (int i = 0; i < NW; i++) ref_mem[i] = DW'(5 + 15 * i);

    // Reset state with idle inputs
    #2;
    check("rst_empty", empty, 1);
    check("rst_full", full, 0);
    check("rst_count", count, 0);
    check("rst_stall", stall, 0);
    check("rst_cpu_rdata", cpu_rdata, 0);
    check("rst_mem_MemWrite", mem_if.mem_MemWrite, 0);
    check("rst_mem_MemRead", mem_if.mem_MemRead, 0);
    check("rst_mem_addr", mem_if.mem_addr, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // SW 0x8 <= 0xAA, then it drains on the next idle cycle
    cycle(0, 1, 32'h8, 32'hAA, done);
    cycle(0, 0, 32'h0, 32'h0, done);
    #1;
    check("sw_count_after_edge", count, 1);
    check("sw_drain_we", mem_if.mem_MemWrite, 1);
    check("sw_drain_addr", mem_if.mem_addr, 32'h8);
    cycle(0, 0, 32'h0, 32'h0, done);
    #1;
    check("sw_empty_after", empty, 1);
    check("sw_mem2", dmem[2], 32'hAA);

    // LW 0x4 while SW 0x4 <= 0x77 is pending (mem[1] = 20)
    cycle(0, 1, 32'h4, 32'h77, done);
    cycle(1, 0, 32'h4, 32'h0, done);
    #1;
    check("hazard_stall", stall, !FWD);
    if (!done) begin
      cycle(1, 0, 32'h4, 32'h0, done);
      #1;
    end
    check("hazard_rdata", cpu_rdata, 32'h77);

    // Two stores to 0xC, then LW 0xC returns the younger value
    cycle(0, 1, 32'hC, 32'h11, done);
    cycle(0, 1, 32'hC, 32'h22, done);
    do_op(1, 0, 32'hD, 32'h0);
    #1;
    check("youngest_rdata", cpu_rdata, 32'h22);

    // Miss load with a store pending: memory data, no drain, count held
    cycle(0, 1, 32'h10, 32'h33, done);
    cycle(1, 0, 32'h0, 32'h0, done);
    #1;
    check("miss_rdata", cpu_rdata, 32'd5);
    check("miss_no_drain", mem_if.mem_MemWrite, 0);
    check("miss_mem_read", mem_if.mem_MemRead, 1);
    cycle(0, 0, 32'h0, 32'h0, done);

    // Load and store raised together: store wins, cpu_rdata = 0
    cycle(1, 1, 32'h14, 32'h5A, done);
    #1;
    check("both_rdata_zero", cpu_rdata, 0);
    cycle(0, 0, 32'h0, 32'h0, done);

    // Reset lands while a store is draining
    cycle(0, 1, 32'h20, 32'h55, done);
    @(posedge clk);
    #1;
    cpu_MemWrite = 1'b0;
    cpu_MemRead  = 1'b0;
    cpu_addr     = '0;
    #1;
    check("pre_rst_drain", mem_if.mem_MemWrite, 1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_count", count, 0);
    check("mid_rst_we", mem_if.mem_MemWrite, 0);
    check("mid_rst_empty", empty, 1);
    pq.delete();
    wr_q.delete();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    check("rst_dropped_store", dmem[8], ref_mem[8]);

    // Randomised traffic over a 16-word window
    for (int t = 0; t < 400; t++) begin
      int            kind;
      logic [AW-1:0] a;
      kind = $urandom_range(0, 19);
      a    = AW'($urandom_range(0, 63));
      if (kind < 8)       do_op(1, 0, a, '0);
      else if (kind < 16) do_op(0, 1, a, DW'($urandom));
      else if (kind < 19) do_op(0, 0, a, '0);
      else                do_op(1, 1, a, DW'($urandom));
    end

    repeat (3) cycle(0, 0, 32'h0, 32'h0, done);
    @(negedge clk);
    #1;
    check("end_empty", empty, 1);
    check("end_wr_q_drained", wr_q.size(), 0);
    check("end_rd_q_drained", rd_q.size(), 0);
    for (int i = 0; i < NW; i++) check("end_mem_word", dmem[i], ref_mem[i]);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
